// File: rtl/mips_multicycle_sequencer_if.sv
// mips_multicycle_sequencer_if
//   Bus between the multi-cycle sequencer and the rest of the MIPS core.
//   Control-unit flags, ALU zero and immediates flow in. The IMEM address
//   and the phase strobes flow out.
//   master : sequencer side (drives ReadAddr and the strobes)
//   slave  : datapath / control-unit side (drives the flags and fields)
interface mips_multicycle_sequencer_if;
    logic        Branch;
    logic        Jump;
    logic        MemRead;
    logic        MemWrite;
    logic        Zero;
    logic [31:0] SEImm;
    logic [25:0] JumpValue;
    logic [7:0]  ReadAddr;
    logic        IRWrite;
    logic        MemEn;
    logic        RegWriteEn;

    modport master (
        input  Branch, Jump, MemRead, MemWrite, Zero, SEImm, JumpValue,
        output ReadAddr, IRWrite, MemEn, RegWriteEn
    );
    modport slave (
        output Branch, Jump, MemRead, MemWrite, Zero, SEImm, JumpValue,
        input  ReadAddr, IRWrite, MemEn, RegWriteEn
    );
endinterface

// File: rtl/mips_multicycle_sequencer.sv
// mips_multicycle_sequencer
//   Owns the PC and steps each instruction through FETCH/DECODE/EXEC/MEM/WB.
//   Resolves jump and branch targets in EXEC, gates DMEM and register-file
//   writes to their phase, halts on a jump-to-self and counts retirements.
//   Optional macro SINGLE_STEP_EN adds the 'step' port (one instruction
//   per pulse from IDLE while run=0).
// Ports:
//   clk, reset  : clock, asynchronous active-high reset
//   run         : level, 1 = execute, 0 = stop at next instruction boundary
//   step        : single-step pulse (SINGLE_STEP_EN only)
//   bus         : control flags in, ReadAddr/IRWrite/MemEn/RegWriteEn out
//   state       : current state encoding
//   halted      : sticky halt indicator
//   retired     : retired-instruction count (wraps)
module mips_multicycle_sequencer #(
    parameter int PC_W  = 7,
    parameter int RET_W = 16
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         run,
`ifdef SINGLE_STEP_EN
    input  logic                         step,
`endif
    mips_multicycle_sequencer_if.master  bus,
    output logic [2:0]                   state,
    output logic                         halted,
    output logic [RET_W-1:0]             retired
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_HALT   = 3'd6
    } state_t;

    state_t            state_q, state_d;
    logic [PC_W-1:0]   pc_q, pc_d;
    logic              halted_q, halted_d;
    logic [RET_W-1:0]  retired_q, retired_d;
    logic              retire;

    logic [PC_W-1:0]   pc_plus4;
    logic [PC_W-1:0]   jump_tgt;
    logic [PC_W-1:0]   br_off;

    assign pc_plus4 = pc_q + PC_W'(4);
    // Word-aligned targets; upper immediate bits fall off because PC wraps.
    assign jump_tgt = {bus.JumpValue[PC_W-3:0], 2'b00};
    assign br_off   = {bus.SEImm[PC_W-3:0], 2'b00};

    logic unused_bits;
    assign unused_bits = ^{bus.SEImm[31:PC_W-2], bus.JumpValue[25:PC_W-2]};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= S_IDLE;
            pc_q      <= '0;
            halted_q  <= 1'b0;
            retired_q <= '0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            halted_q  <= halted_d;
            retired_q <= retired_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        halted_d  = halted_q;
        retired_d = retired_q;
        retire    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (run) state_d = S_FETCH;
`ifdef SINGLE_STEP_EN
                else if (step) state_d = S_FETCH;
`endif
            end
            S_FETCH:  state_d = S_DECODE;
            S_DECODE: state_d = S_EXEC;
            S_EXEC: begin
                if (bus.Jump) begin
                    if (jump_tgt == pc_q) begin
                        state_d  = S_HALT;
                        halted_d = 1'b1;
                    end else begin
                        pc_d   = jump_tgt;
                        retire = 1'b1;
                    end
                end else if (bus.Branch) begin
                    pc_d   = bus.Zero ? pc_plus4 + br_off : pc_plus4;
                    retire = 1'b1;
                end else if (bus.MemRead || bus.MemWrite) begin
                    state_d = S_MEM;
                end else begin
                    state_d = S_WB;
                end
            end
            S_MEM: begin
                // Store wins when both flags are up; flags dropping to
                // neither finishes through WB like an ALU op.
                if (bus.MemWrite) begin
                    pc_d   = pc_plus4;
                    retire = 1'b1;
                end else begin
                    state_d = S_WB;
                end
            end
            S_WB: begin
                pc_d   = pc_plus4;
                retire = 1'b1;
            end
            S_HALT:  state_d = S_HALT;
            default: state_d = S_IDLE;
        endcase
        if (retire) begin
            retired_d = retired_q + RET_W'(1);
            state_d   = run ? S_FETCH : S_IDLE;
        end
    end

    assign bus.ReadAddr   = 8'(pc_q);
    assign bus.IRWrite    = (state_q == S_FETCH);
    assign bus.MemEn      = (state_q == S_MEM);
    assign bus.RegWriteEn = (state_q == S_WB);
    assign state          = state_q;
    assign halted         = halted_q;
    assign retired        = retired_q;

endmodule

// File: tb/tb_mips_multicycle_sequencer.sv
// tb_mips_multicycle_sequencer
//   Randomised instruction stream against a per-instruction reference model
//   (phase list, next PC, retire count) plus the directed scenarios.
module tb_mips_multicycle_sequencer;

    logic        clk;
    logic        reset;
    logic        run;
    logic        step;
    logic [2:0]  state;
    logic        halted;
    logic [15:0] retired;

    mips_multicycle_sequencer_if bus();

    mips_multicycle_sequencer #(.PC_W(7), .RET_W(16)) dut (
        .clk     (clk),
        .reset   (reset),
        .run     (run),
`ifdef SINGLE_STEP_EN
        .step    (step),
`endif
        .bus     (bus.master),
        .state   (state),
        .halted  (halted),
        .retired (retired)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    int m_pc;
    int m_ret;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int mod128(input int x);
        return ((x % 128) + 128) % 128;
    endfunction

    task automatic drive(input logic j, b, mr, mw, z, input logic [31:0] imm, input logic [25:0] jv);
        bus.Jump = j; bus.Branch = b; bus.MemRead = mr; bus.MemWrite = mw;
        bus.Zero = z; bus.SEImm = imm; bus.JumpValue = jv;
    endtask

    task automatic drive_junk();
        drive(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
              1'($urandom), $urandom, 26'($urandom));
    endtask

    // Expects the DUT to be in its FETCH cycle at entry (sampled on negedge).
    task automatic do_instr(input logic j, b, mr, mw, z, input logic [31:0] imm,
                            input logic [25:0] jv, input bit drop_run);
        int seq[$];
        int nxt;
        int tgt;
        bit hlt;
        seq = '{1, 2, 3};
        nxt = mod128(m_pc + 4);
        hlt = 0;
        tgt = mod128(int'(jv) * 4);
        if (j) begin
            if (tgt == m_pc) hlt = 1;
            else nxt = tgt;
        end else if (b) begin
            if (z) nxt = mod128(m_pc + 4 + int'($signed(imm)) * 4);
        end else if (mw) begin
            seq.push_back(4);
        end else if (mr) begin
            seq.push_back(4);
            seq.push_back(5);
        end else begin
            seq.push_back(5);
        end
        for (int i = 0; i < seq.size(); i++) begin
            chk("state", 32'(state), 32'(seq[i]));
            chk("IRWrite", 32'(bus.IRWrite), 32'(seq[i] == 1));
            chk("MemEn", 32'(bus.MemEn), 32'(seq[i] == 4));
            chk("RegWriteEn", 32'(bus.RegWriteEn), 32'(seq[i] == 5));
            chk("ReadAddr", 32'(bus.ReadAddr), 32'(m_pc));
            chk("retired_hold", 32'(retired), 32'(m_ret));
            // Flags only matter while EXEC/MEM is about to be clocked out.
            if (seq[i] == 3 || seq[i] == 4) drive(j, b, mr, mw, z, imm, jv);
            else drive_junk();
            if (drop_run && i == 1) run = 1'b0;
            @(negedge clk);
        end
        if (hlt) begin
            chk("halt_state", 32'(state), 32'd6);
            chk("halted", 32'(halted), 32'd1);
            chk("halt_pc", 32'(bus.ReadAddr), 32'(m_pc));
            chk("halt_ret", 32'(retired), 32'(m_ret));
        end else begin
            m_pc  = nxt;
            m_ret = (m_ret + 1) % 65536;
            chk("post_state", 32'(state), run ? 32'd1 : 32'd0);
            chk("post_pc", 32'(bus.ReadAddr), 32'(m_pc));
            chk("post_ret", 32'(retired), 32'(m_ret));
            chk("post_halted", 32'(halted), 32'd0);
            if (drop_run) begin
                run = 1'b1;
                @(negedge clk);
                chk("resume", 32'(state), 32'd1);
            end
        end
    endtask

    task automatic jump_to(input int target);
        do_instr(1, 0, 0, 0, 0, 32'd0, 26'(target / 4), 0);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        #1;
        m_pc = 0; m_ret = 0;
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic j, b, mr, mw, z;
        logic [31:0] imm;
        logic [25:0] jv;
        reset = 1'b1; run = 1'b0; step = 1'b0;
        drive(0, 0, 0, 0, 0, 32'd0, 26'd0);
        m_pc = 0; m_ret = 0;
        @(negedge clk); @(negedge clk);
        chk("rst_state", 32'(state), 32'd0);
        chk("rst_addr", 32'(bus.ReadAddr), 32'd0);
        chk("rst_strobes", {29'd0, bus.IRWrite, bus.MemEn, bus.RegWriteEn}, 32'd0);
        chk("rst_halted", 32'(halted), 32'd0);
        chk("rst_retired", 32'(retired), 32'd0);
        reset = 1'b0;
        @(negedge clk); @(negedge clk);
        chk("idle_hold", 32'(state), 32'd0);
        run = 1'b1;
        @(negedge clk);

        // R-type from 0, then load at 8
        do_instr(0, 0, 0, 0, 0, 32'd0, 26'd0, 0);
        do_instr(0, 0, 0, 0, 0, 32'd0, 26'd0, 0);
        do_instr(0, 0, 1, 0, 0, 32'd0, 26'd0, 0);
        chk("lw_pc12", 32'(bus.ReadAddr), 32'd12);
        // store, and both mem flags (store wins)
        do_instr(0, 0, 0, 1, 0, 32'd0, 26'd0, 0);
        do_instr(0, 0, 1, 1, 0, 32'd0, 26'd0, 0);

        // beq at 0x20 with SEImm=-3
        jump_to(32'h20);
        do_instr(0, 1, 0, 0, 1, 32'hFFFF_FFFD, 26'd0, 0);
        chk("beq_taken", 32'(bus.ReadAddr), 32'h18);
        jump_to(32'h20);
        do_instr(0, 1, 0, 0, 0, 32'hFFFF_FFFD, 26'd0, 0);
        chk("beq_not_taken", 32'(bus.ReadAddr), 32'h24);

        // wrap from 124, forward branch wrap
        jump_to(124);
        do_instr(0, 0, 0, 0, 0, 32'd0, 26'd0, 0);
        chk("wrap_pc", 32'(bus.ReadAddr), 32'd0);
        jump_to(120);
        do_instr(0, 1, 0, 0, 1, 32'd2, 26'd0, 0);
        chk("br_wrap", 32'(bus.ReadAddr), 32'd4);

        // run dropped mid-instruction
        do_instr(0, 0, 1, 0, 0, 32'd0, 26'd0, 1);

        // random stream
        for (int n = 0; n < 300; n++) begin
            j = 0; b = 0; mr = 0; mw = 0;
            z = 1'($urandom); imm = $urandom; jv = 26'($urandom);
            case ($urandom_range(0, 5))
                0: j = 1;
                1: b = 1;
                2: mr = 1;
                3: mw = 1;
                4: ;
                default: begin
                    j = 1'($urandom); b = 1'($urandom);
                    mr = 1'($urandom); mw = 1'($urandom);
                end
            endcase
            if (j && mod128(int'(jv) * 4) == m_pc) jv = jv + 26'd1;
            do_instr(j, b, mr, mw, z, imm, jv, ($urandom_range(0, 7) == 0));
        end

        // reset mid-WB with PC=0x10
        jump_to(32'h10);
        drive(0, 0, 0, 0, 0, 32'd0, 26'd0);
        @(negedge clk); @(negedge clk); @(negedge clk);
        chk("pre_rst_wb", 32'(state), 32'd5);
        chk("pre_rst_pc", 32'(bus.ReadAddr), 32'h10);
        do_reset();
        chk("rstwb_state", 32'(state), 32'd0);
        chk("rstwb_addr", 32'(bus.ReadAddr), 32'd0);
        chk("rstwb_ret", 32'(retired), 32'd0);
        chk("rstwb_strobes", {29'd0, bus.IRWrite, bus.MemEn, bus.RegWriteEn}, 32'd0);
        @(negedge clk);
        chk("rstwb_fetch", 32'(state), 32'd1);

        // jump to self halts
        jump_to(32'h10);
        do_instr(1, 0, 0, 0, 0, 32'd0, 26'd5, 0);
        chk("j_0x14", 32'(bus.ReadAddr), 32'h14);
        do_instr(1, 0, 0, 0, 0, 32'd0, 26'd5, 0);
        for (int i = 0; i < 6; i++) begin
            run = ~run;
            drive_junk();
            @(negedge clk);
            chk("halt_hold", 32'(state), 32'd6);
            chk("halt_addr", 32'(bus.ReadAddr), 32'h14);
            chk("halt_strobes", {29'd0, bus.IRWrite, bus.MemEn, bus.RegWriteEn}, 32'd0);
            chk("halt_ret_hold", 32'(retired), 32'(m_ret));
        end
        run = 1'b0;
        do_reset();
        chk("halt_exit", 32'(state), 32'd0);
        chk("halt_clr", 32'(halted), 32'd0);

`ifdef SINGLE_STEP_EN
        @(negedge clk);
        chk("step_idle", 32'(state), 32'd0);
        step = 1'b1;
        @(negedge clk);
        step = 1'b0;
        do_instr(0, 0, 1, 0, 0, 32'd0, 26'd0, 0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("step_stay_idle", 32'(state), 32'd0);
            chk("step_one_ret", 32'(retired), 32'd1);
        end
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
